cfg_chain_programmer: RTL and testbench
=======================================

Name: cfg_chain_programmer

Overview:
- Host-side driver for the serial configuration chain used by the CB/CLB tiles (prog_in / prog_en / prog_out, one bit per prog_clk edge).
- Takes a parallel bitstream, shifts it into the chain LSB first, and optionally re-shifts it while comparing prog_out for readback verification.
- Sits between the configuration controller/testbench and the first tile's prog_in. The tile's prog_out returns to this block.

Parameters:
- CHAIN_LEN, 69, total number of configuration bits in the chain (CB chain is 69).
- CNT_W, 7, bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  configuration clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to program; sampled only in IDLE.
- verify_en  input  1  sampled with start; 1 = run a readback pass after the load.
- bitstream  input  CHAIN_LEN  configuration image; bit 0 is shifted first.
- prog_in  output  1  serial data to the chain.
- prog_en  output  1  chain shift enable.
- prog_out  input  1  serial data returning from the end of the chain.
- busy  output  1  high from start acceptance until done.
- done  output  1  single-cycle completion pulse.
- err  output  1  sticky readback-mismatch flag; cleared on the next accepted start.
- err_idx  output  CNT_W  index of the first mismatching bit; valid when err=1.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - prog_in, prog_en, busy, done, err and err_idx are all 0 immediately.
  - A reset in mid-load drops prog_en at once, so the chain keeps whatever partial contents it had. There is no resume.
- All outputs are registered; the chain samples them on the following prog_clk rising edge.
- States:
  - IDLE: busy=0, prog_en=0. If start=1, the block does the following on that edge:
    - captures bitstream into a shadow register and verify_en into a flag;
    - clears err and err_idx;
    - sets cnt=0, busy=1, prog_en=1, prog_in=shadow[0];
    - moves to LOAD.
  - LOAD: each edge increments cnt and sets prog_in=shadow[cnt+1].
    - When cnt=CHAIN_LEN-1, the last bit is being taken by the chain.
    - If the verify flag is set, go to VERIFY with cnt=0, prog_in=shadow[0], prog_en staying 1. Otherwise go to FINISH.
    - prog_en is high for exactly CHAIN_LEN consecutive cycles in a plain load.
  - VERIFY: re-shifts the same image, so the configuration is restored when the pass ends.
    - On each edge, compare prog_out with shadow[cnt]. On the chain-shift edge, prog_out presents first-pass bit cnt.
    - On the first mismatch, set err=1 and err_idx=cnt. Later mismatches do not change err_idx.
    - At cnt=CHAIN_LEN-1, go to FINISH.
  - FINISH: the next edge drives prog_en=0, prog_in=0, busy=0, done=1 (one cycle), then returns to IDLE.
- Latency from start edge to done high:
  - without verify: CHAIN_LEN+1 cycles;
  - with verify: 2*CHAIN_LEN+1 cycles.
- start while busy=1 is ignored and not queued.
- start held high continuously: a new run is accepted on the cycle after done, since the block is back in IDLE.
- bitstream and verify_en changes after acceptance have no effect (shadowed).
- prog_in is 0 whenever prog_en=0.
- The counter never wraps; its terminal value is CHAIN_LEN-1.

Test Plan:
- Bench chain model: a CHAIN_LEN shift register that shifts on prog_clk when prog_en=1. New bit enters at the top; prog_out is bit 0.
- Plain load: bitstream=69'b11101110111011100_01100100010101000111001101010001_00000000000000000000, verify_en=0 -> prog_en high exactly 69 cycles, model equals bitstream, done pulse 70 cycles after start, err=0.
- Verify pass, good chain: same image with verify_en=1 -> prog_en high 138 cycles, err=0, model still equals bitstream, done after 139 cycles.
- Verify with fault: model bit 5 stuck-at-0 and bitstream[5]=1 (alternating 1010... image) -> err=1, err_idx=5, busy=0 after done.
- start pulsed at cycle 20 of a load, bitstream changed mid-run -> ignored; model equals the originally captured image; one done pulse only.
- rst_n asserted at load cycle 30 -> prog_en, busy and done are 0 without a clock edge. After release, a new start with all-ones performs a full 69-cycle load and the model becomes all ones.
- Back-to-back: start held high across two runs (second with verify_en=1) -> second busy rises the cycle after the first done; err from the first run is cleared at the second acceptance.

Source files
------------

// File: rtl/cfg_chain_programmer_if.sv
// Host/chain-side signal bundle for the serial configuration chain programmer.
// The slave view belongs to the programmer; the master view to the host plus the chain.
interface cfg_chain_programmer_if #(
    parameter int CHAIN_LEN = 69,
    parameter int CNT_W     = 7
);
    logic                 start;
    logic                 verify_en;
    logic [CHAIN_LEN-1:0] bitstream;
    logic                 prog_in;
    logic                 prog_en;
    logic                 prog_out;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [CNT_W-1:0]     err_idx;

    modport slave (
        input  start, verify_en, bitstream, prog_out,
        output prog_in, prog_en, busy, done, err, err_idx
    );

    modport master (
        output start, verify_en, bitstream, prog_out,
        input  prog_in, prog_en, busy, done, err, err_idx
    );
endinterface

// File: rtl/cfg_chain_programmer.sv
// Shifts a parallel configuration image into the tile chain LSB first, with an
// optional second pass that restores the image while checking what returns on prog_out.
module cfg_chain_programmer #(
    parameter int CHAIN_LEN = 69,
    parameter int CNT_W     = 7
) (
    input logic                   prog_clk,
    input logic                   rst_n,
    cfg_chain_programmer_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
    logic [CHAIN_LEN-1:0] shadow, shadow_n;
    logic                 vflag, vflag_n;
    logic                 in_q, in_n;
    logic                 en_q, en_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 err_q, err_n;
    logic [CNT_W-1:0]     idx_q, idx_n;

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            vflag  <= 1'b0;
            in_q   <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            idx_q  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            vflag  <= vflag_n;
            in_q   <= in_n;
            en_q   <= en_n;
            busy_q <= busy_n;
            done_q <= done_n;
            err_q  <= err_n;
            idx_q  <= idx_n;
        end
    end

    // prog_en/prog_in default low so the chain never shifts outside a run.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shadow_n = shadow;
        vflag_n  = vflag;
        in_n     = 1'b0;
        en_n     = 1'b0;
        busy_n   = busy_q;
        done_n   = 1'b0;
        err_n    = err_q;
        idx_n    = idx_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    shadow_n = bus.bitstream;
                    vflag_n  = bus.verify_en;
                    err_n    = 1'b0;
                    idx_n    = '0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    en_n     = 1'b1;
                    in_n     = bus.bitstream[0];
                    state_n  = LOAD;
                end
            end
            LOAD: begin
                if (cnt == LAST) begin
                    if (vflag) begin
                        cnt_n   = '0;
                        en_n    = 1'b1;
                        in_n    = shadow[0];
                        state_n = VERIFY;
                    end else begin
                        state_n = FINISH;
                    end
                end else begin
                    cnt_n = cnt_inc;
                    en_n  = 1'b1;
                    in_n  = shadow[cnt_inc];
                end
            end
            VERIFY: begin
                // prog_out carries first-pass bit cnt on the same edge that reloads it.
                if (bus.prog_out != shadow[cnt] && !err_q) begin
                    err_n = 1'b1;
                    idx_n = cnt;
                end
                if (cnt == LAST) begin
                    state_n = FINISH;
                end else begin
                    cnt_n = cnt_inc;
                    en_n  = 1'b1;
                    in_n  = shadow[cnt_inc];
                end
            end
            FINISH: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.prog_in = in_q;
    assign bus.prog_en = en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.err_idx = idx_q;
endmodule

// File: tb/tb_cfg_chain_programmer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor
// pops and checks them on every done pulse against a behavioural chain model.
module tb_cfg_chain_programmer;
    localparam int CHAIN_LEN = 69;
    localparam int CNT_W     = 7;

    localparam logic [CHAIN_LEN-1:0] IMG_A    = 69'b11101110111011100_01100100010101000111001101010001_00000000000000000000;
    localparam logic [CHAIN_LEN-1:0] IMG_ALT  = {1'b0, {17{4'hA}}};
    localparam logic [CHAIN_LEN-1:0] IMG_B    = 69'h1F_0F0F_3C3C_A5A5_9669;
    localparam logic [CHAIN_LEN-1:0] IMG_ONES = '1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cfg_chain_programmer_if #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) bus ();

    cfg_chain_programmer #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
        .prog_clk(clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // Chain model: new bit enters at the top, prog_out is bit 0. With stuck5 set,
    // cell 5 reads 0 once the chain has been fully loaded.
    logic [CHAIN_LEN-1:0] chain;
    int unsigned          run_len;
    logic                 stuck5 = 1'b0;

    function automatic logic [CHAIN_LEN-1:0] shift_in(input logic [CHAIN_LEN-1:0] c,
                                                      input logic b, input logic kill5);
        logic [CHAIN_LEN-1:0] n;
        n = {b, c[CHAIN_LEN-1:1]};
        if (kill5) n[5] = 1'b0;
        return n;
    endfunction

    always @(posedge clk) begin
        if (bus.prog_en) begin
            chain   <= shift_in(chain, bus.prog_in, stuck5 && (run_len >= CHAIN_LEN - 1));
            run_len <= run_len + 1;
        end else begin
            run_len <= 0;
        end
    end
    assign bus.prog_out = chain[0];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string                name;
        logic [CHAIN_LEN-1:0] img;
        logic                 chk_chain;
        logic                 err;
        logic [CNT_W-1:0]     idx;
        int unsigned          lat;
        int unsigned          en_len;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_push   = 0;
    int unsigned n_done   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input string name, input logic [CHAIN_LEN-1:0] img, input logic chk,
                            input logic err, input logic [CNT_W-1:0] idx,
                            input int unsigned lat, input int unsigned en_len);
        exp_t e;
        e.name = name; e.img = img; e.chk_chain = chk; e.err = err;
        e.idx = idx; e.lat = lat; e.en_len = en_len;
        sb.push_back(e);
        n_push++;
    endtask

    // Monitor: tracks run timing from the busy rise and checks each completed run.
    initial begin
        exp_t        e;
        logic        busy_q  = 1'b0;
        int unsigned t_start = 0;
        int unsigned en_cnt  = 0;
        int unsigned in_viol = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_q = 1'b0;
                en_cnt = 0;
            end else begin
                if (bus.busy && !busy_q) begin
                    t_start = cyc;
                    en_cnt  = 0;
                    in_viol = 0;
                end
                if (bus.prog_en) en_cnt++;
                if (!bus.prog_en && bus.prog_in) in_viol++;
                if (bus.done) begin
                    n_done++;
                    check("done_expected", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check($sformatf("%s_latency", e.name), cyc - t_start, e.lat);
                        check($sformatf("%s_en_len", e.name), en_cnt, e.en_len);
                        check($sformatf("%s_err", e.name), bus.err, e.err);
                        check($sformatf("%s_err_idx", e.name), bus.err_idx, e.idx);
                        check($sformatf("%s_busy_low", e.name), bus.busy, 1'b0);
                        check($sformatf("%s_prog_in_idle", e.name), in_viol, 0);
                        if (e.chk_chain) check($sformatf("%s_chain", e.name), chain, e.img);
                    end
                end
                busy_q = bus.busy;
            end
        end
    end

    task automatic start_pulse(input logic [CHAIN_LEN-1:0] img, input logic ver);
        @(negedge clk);
        bus.bitstream = img;
        bus.verify_en = ver;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check($sformatf("%s_done_seen", name), seen, 1'b1);
    endtask

    initial begin
        int unsigned done_before;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.verify_en = 1'b0;
        bus.bitstream = '0;
        #12;
        check("reset_outputs", {bus.prog_en, bus.prog_in, bus.busy, bus.done, bus.err, bus.err_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        push_exp("plain", IMG_A, 1'b1, 1'b0, '0, CHAIN_LEN + 1, CHAIN_LEN);
        start_pulse(IMG_A, 1'b0);
        wait_done("plain");

        push_exp("verify_good", IMG_A, 1'b1, 1'b0, '0, 2 * CHAIN_LEN + 1, 2 * CHAIN_LEN);
        start_pulse(IMG_A, 1'b1);
        wait_done("verify_good");

        stuck5 = 1'b1;
        push_exp("verify_fault", IMG_ALT, 1'b0, 1'b1, 7'd5, 2 * CHAIN_LEN + 1, 2 * CHAIN_LEN);
        start_pulse(IMG_ALT, 1'b1);
        wait_done("verify_fault");
        stuck5 = 1'b0;
        @(negedge clk);
        check("err_sticky", {bus.err, bus.err_idx}, {1'b1, 7'd5});

        // Second start and new image mid-load must not disturb the captured run.
        done_before = n_done;
        push_exp("midrun", IMG_B, 1'b1, 1'b0, '0, CHAIN_LEN + 1, CHAIN_LEN);
        start_pulse(IMG_B, 1'b0);
        repeat (19) @(negedge clk);
        bus.bitstream = ~IMG_B;
        bus.verify_en = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("midrun");
        repeat (100) @(negedge clk);
        check("midrun_single_done", n_done - done_before, 1);

        start_pulse(IMG_A, 1'b0);
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.prog_en, bus.prog_in, bus.busy, bus.done}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp("ones_after_reset", IMG_ONES, 1'b1, 1'b0, '0, CHAIN_LEN + 1, CHAIN_LEN);
        start_pulse(IMG_ONES, 1'b0);
        wait_done("ones_after_reset");

        // start held high: the second run should be accepted right after the first done.
        stuck5 = 1'b1;
        push_exp("b2b_first", IMG_ALT, 1'b0, 1'b1, 7'd5, 2 * CHAIN_LEN + 1, 2 * CHAIN_LEN);
        push_exp("b2b_second", IMG_B, 1'b1, 1'b0, '0, 2 * CHAIN_LEN + 1, 2 * CHAIN_LEN);
        @(negedge clk);
        bus.bitstream = IMG_ALT;
        bus.verify_en = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.bitstream = IMG_B;
        wait_done("b2b_first");
        stuck5 = 1'b0;
        @(negedge clk);
        check("b2b_busy_next_cycle", bus.busy, 1'b1);
        check("b2b_err_cleared", {bus.err, bus.err_idx}, 0);
        bus.start = 1'b0;
        wait_done("b2b_second");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", n_done, n_push);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
